pong_game_controller: RTL and testbench

- Sequences the pong game: idle, serve countdown, rally, point-lost pause, game over.
- Gates ball motion with a programmable step timer that speeds up on every paddle hit.
- Keeps BCD score and remaining lives.
- Sits beside the pixel/ball datapath in the VGA clock domain. It consumes collision events from that datapath and drives its ball-step, recentre and visibility controls.

---
 rtl/pong_pkg.sv | 41 ++++
 rtl/pong_step_timer.sv | 63 ++++++
 rtl/pong_game_controller.sv | 163 ++++++++++++++++
 tb/tb_pong_game_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_pkg : shared state encoding, timing defaults and BCD helper     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int DEF_PERIOD_INIT  = 5000;
  localparam int DEF_PERIOD_DEC   = 250;
  localparam int DEF_PERIOD_MIN   = 1000;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_MISS_FRAMES  = 90;

  localparam int BCD_W       = 4;
  localparam int FRAME_CNT_W = 8;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [2*BCD_W-1:0] bcd_inc_sat(input logic [2*BCD_W-1:0] v);
    logic [BCD_W-1:0] lo;
    logic [BCD_W-1:0] hi;
    lo = v[BCD_W-1:0];
    hi = v[2*BCD_W-1:BCD_W];
    if (lo == BCD_W'(9) && hi == BCD_W'(9)) begin
      return v;
    end
    if (lo == BCD_W'(9)) begin
      return {hi + BCD_W'(1), BCD_W'(0)};
    end
    return {hi, lo + BCD_W'(1)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_step_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_step_timer : shrinking-period ball step pulse generator         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pong_step_timer
  import pong_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int PERIOD_INIT = DEF_PERIOD_INIT,
  parameter int PERIOD_DEC  = DEF_PERIOD_DEC,
  parameter int PERIOD_MIN  = DEF_PERIOD_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic hit_dec,
  input  logic reload,
  output logic step
);

  localparam logic [PERIOD_W-1:0] INIT_V = PERIOD_W'(PERIOD_INIT);
  localparam logic [PERIOD_W-1:0] DEC_V  = PERIOD_W'(PERIOD_DEC);
  localparam logic [PERIOD_W-1:0] MIN_V  = PERIOD_W'(PERIOD_MIN);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] count;
  logic                at_end;
  logic                can_dec;

  // >= rather than == so a period shrinking below the live count still steps.
  assign at_end  = count >= (period - PERIOD_W'(1));
  assign can_dec = (period > MIN_V) && ((period - MIN_V) >= DEC_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= INIT_V;
      count  <= '0;
      step   <= 1'b0;
    end else begin
      if (reload) begin
        period <= INIT_V;
      end else if (hit_dec) begin
        period <= can_dec ? (period - DEC_V) : MIN_V;
      end

      step <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (enable) begin
        if (at_end) begin
          count <= '0;
          step  <= 1'b1;
        end else begin
          count <= count + PERIOD_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_game_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_game_controller : game sequencer, BCD score, lives, step gating |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pong_game_controller
  import pong_pkg::*;
#(
  parameter int PERIOD_W     = 16,
  parameter int PERIOD_INIT  = DEF_PERIOD_INIT,
  parameter int PERIOD_DEC   = DEF_PERIOD_DEC,
  parameter int PERIOD_MIN   = DEF_PERIOD_MIN,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int MISS_FRAMES  = DEF_MISS_FRAMES,
  parameter int LIVES_INIT   = 3
) (
  input  logic       VGA_CLOCK,
  input  logic       RESET,
  input  logic       FRAME_START,
  input  logic       START,
  input  logic       PADDLE_HIT,
  input  logic       BALL_MISS,
  output logic       BALL_STEP,
  output logic       BALL_RECENTRE,
  output logic       BALL_VISIBLE,
  output logic       SERVE_DIR,
  output logic [7:0] SCORE,
  output logic [1:0] LIVES,
  output logic       GAME_OVER,
  output logic [2:0] STATE
);

  state_t                 state;
  state_t                 state_d;
  logic                   start_q;
  logic                   start_rise;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  logic [7:0]             score_d;
  logic [1:0]             lives_d;
  logic                   dir_d;
  logic                   recentre_d;
  logic                   tmr_clear;
  logic                   tmr_enable;
  logic                   tmr_hit;
  logic                   tmr_reload;

  assign start_rise = START & ~start_q;
  assign STATE      = state;

  always_comb begin
    state_d     = state;
    frame_cnt_d = frame_cnt;
    score_d     = SCORE;
    lives_d     = LIVES;
    dir_d       = SERVE_DIR;
    recentre_d  = 1'b0;
    tmr_hit     = 1'b0;
    tmr_reload  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_SERVE;
          recentre_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (FRAME_START) begin
          if (frame_cnt == FRAME_CNT_W'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt + FRAME_CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // A miss in the same cycle as a hit discards the hit entirely.
        if (BALL_MISS) begin
          lives_d    = LIVES - 2'd1;
          dir_d      = ~SERVE_DIR;
          tmr_reload = 1'b1;
          state_d    = (LIVES == 2'd1) ? ST_OVER : ST_MISS;
        end else if (PADDLE_HIT) begin
          score_d = bcd_inc_sat(SCORE);
          tmr_hit = 1'b1;
        end
      end
      ST_MISS: begin
        if (FRAME_START) begin
          if (frame_cnt == FRAME_CNT_W'(MISS_FRAMES - 1)) begin
            state_d    = ST_SERVE;
            recentre_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt + FRAME_CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          score_d    = 8'h00;
          lives_d    = 2'(LIVES_INIT);
          dir_d      = 1'b0;
          tmr_reload = 1'b1;
          state_d    = ST_SERVE;
          recentre_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state) begin
      frame_cnt_d = '0;
    end
  end

  // Counter held at zero outside PLAY; no step on the cycle PLAY is left.
  assign tmr_clear  = (state != ST_PLAY);
  assign tmr_enable = (state == ST_PLAY) && (state_d == ST_PLAY);

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      start_q       <= 1'b0;
      frame_cnt     <= '0;
      SCORE         <= 8'h00;
      LIVES         <= 2'(LIVES_INIT);
      SERVE_DIR     <= 1'b0;
      BALL_RECENTRE <= 1'b0;
      BALL_VISIBLE  <= 1'b0;
      GAME_OVER     <= 1'b0;
    end else begin
      state         <= state_d;
      start_q       <= START;
      frame_cnt     <= frame_cnt_d;
      SCORE         <= score_d;
      LIVES         <= lives_d;
      SERVE_DIR     <= dir_d;
      BALL_RECENTRE <= recentre_d;
      BALL_VISIBLE  <= (state_d == ST_SERVE) || (state_d == ST_PLAY);
      GAME_OVER     <= (state_d == ST_OVER);
    end
  end

  pong_step_timer #(
    .PERIOD_W    (PERIOD_W),
    .PERIOD_INIT (PERIOD_INIT),
    .PERIOD_DEC  (PERIOD_DEC),
    .PERIOD_MIN  (PERIOD_MIN)
  ) u_step_timer (
    .clk     (VGA_CLOCK),
    .rst     (RESET),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .hit_dec (tmr_hit),
    .reload  (tmr_reload),
    .step    (BALL_STEP)
  );

endmodule
`default_nettype wire

// File: tb/tb_pong_game_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pong_game_controller : scoreboard bench for pong_game_controller  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pong_game_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       start = 1'b0;
  logic       paddle_hit = 1'b0;
  logic       ball_miss = 1'b0;
  logic       ball_step;
  logic       ball_recentre;
  logic       ball_visible;
  logic       serve_dir;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic [2:0] state;

  pong_game_controller dut (
    .VGA_CLOCK     (clk),
    .RESET         (rst),
    .FRAME_START   (frame_start),
    .START         (start),
    .PADDLE_HIT    (paddle_hit),
    .BALL_MISS     (ball_miss),
    .BALL_STEP     (ball_step),
    .BALL_RECENTRE (ball_recentre),
    .BALL_VISIBLE  (ball_visible),
    .SERVE_DIR     (serve_dir),
    .SCORE         (score),
    .LIVES         (lives),
    .GAME_OVER     (game_over),
    .STATE         (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic [7:0] sc;
    logic [1:0] lv;
    logic       dir;
    logic       ov;
    logic       vis;
    logic       step;
    logic       rec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Hand-tracked model of the externally visible game state.
  logic [2:0] m_st = 3'd0;
  int         m_score = 0;
  logic [1:0] m_lives = 2'd3;
  logic       m_dir = 1'b0;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic push(input int at, input logic step_e, input logic rec_e);
    exp_t e;
    e.at   = at;
    e.st   = m_st;
    e.sc   = to_bcd(m_score);
    e.lv   = m_lives;
    e.dir  = m_dir;
    e.ov   = (m_st == 3'd4);
    e.vis  = (m_st == 3'd1) || (m_st == 3'd2);
    e.step = step_e;
    e.rec  = rec_e;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
    end
  endtask

  // Runs n frame pulses; the last one moves to new_st at a predicted cycle.
  task automatic frames_to(input int n, input logic [2:0] new_st, input logic rec_e);
    frames(n - 1);
    frame_start = 1'b1;
    m_st = new_st;
    push(cyc + 1, 1'b0, rec_e);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      paddle_hit = 1'b1;
      if (m_score < 99) begin
        m_score++;
        push(cyc + 1, 1'b0, 1'b0);
      end
      tick();
    end
    paddle_hit = 1'b0;
  endtask

  task automatic miss_event(input logic with_hit);
    ball_miss  = 1'b1;
    paddle_hit = with_hit;
    m_lives    = m_lives - 2'd1;
    m_dir      = ~m_dir;
    m_st       = (m_lives == 2'd0) ? 3'd4 : 3'd3;
    push(cyc + 1, 1'b0, 1'b0);
    tick();
    ball_miss  = 1'b0;
    paddle_hit = 1'b0;
  endtask

  task automatic stray_pulses();
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    paddle_hit  = 1'b1; tick(); paddle_hit  = 1'b0; tick();
    ball_miss   = 1'b1; tick(); ball_miss   = 1'b0; tick();
    frame_start = 1'b1; paddle_hit = 1'b1; ball_miss = 1'b1; tick();
    frame_start = 1'b0; paddle_hit = 1'b0; ball_miss = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  // Monitor: any step/recentre pulse or change of held outputs is an event.
  logic [14:0] prev = '1;
  always @(negedge clk) begin
    logic [14:0] cur;
    exp_t        e;
    cur = {state, score, lives, serve_dir, game_over, ball_visible};
    if (ball_step || ball_recentre || (cur !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got st=%0d sc=%h lv=%0d dir=%0d ov=%0d vis=%0d step=%0d rec=%0d, required no event",
                 cyc, state, score, lives, serve_dir, game_over, ball_visible, ball_step, ball_recentre);
      end else begin
        e = exp_q.pop_front();
        if ((e.at >= 0 && e.at != cyc) || state !== e.st || score !== e.sc || lives !== e.lv ||
            serve_dir !== e.dir || game_over !== e.ov || ball_visible !== e.vis ||
            ball_step !== e.step || ball_recentre !== e.rec) begin
          failures++;
          $display("FAIL event cyc=%0d got st=%0d sc=%h lv=%0d dir=%0d ov=%0d vis=%0d step=%0d rec=%0d, required at=%0d st=%0d sc=%h lv=%0d dir=%0d ov=%0d vis=%0d step=%0d rec=%0d",
                   cyc, state, score, lives, serve_dir, game_over, ball_visible, ball_step, ball_recentre,
                   e.at, e.st, e.sc, e.lv, e.dir, e.ov, e.vis, e.step, e.rec);
        end
      end
    end
    prev = cur;
  end

  initial begin
    int p;

    // Reset values.
    push(-1, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Serve from IDLE, one recentre pulse, 60 frames to PLAY.
    start = 1'b1;
    m_st = 3'd1;
    push(cyc + 1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    start = 1'b0;
    frames_to(60, 3'd2, 1'b0);
    p = cyc;

    // Steps every 5000 cycles at the initial period.
    push(p + 5000, 1'b1, 1'b0);
    push(p + 10000, 1'b1, 1'b0);
    wait_until(p + 10000);

    // Four hits: period 4000.
    hits(4);
    push(p + 14000, 1'b1, 1'b0);
    wait_until(p + 14000);

    // Sixteen more hits: period floors at 1000, score 20.
    hits(16);
    push(p + 15000, 1'b1, 1'b0);
    wait_until(p + 15000);

    // Drive score to 99, then one more hit that must not change it.
    hits(80);
    push(p + 16000, 1'b1, 1'b0);
    wait_until(p + 16000);

    // Reset mid-count in PLAY.
    wait_until(p + 16500);
    m_st = 3'd0;
    m_score = 0;
    m_lives = 2'd3;
    m_dir = 1'b0;
    push(cyc, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Stray events in IDLE have no effect.
    stray_pulses();

    // New game: period back to 5000 after reset.
    start = 1'b1;
    m_st = 3'd1;
    push(cyc + 1, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    frames_to(60, 3'd2, 1'b0);
    p = cyc;
    push(p + 5000, 1'b1, 1'b0);
    wait_until(p + 5000);
    hits(5);

    // Hit and miss together: miss wins.
    miss_event(1'b1);
    frames_to(90, 3'd1, 1'b1);

    // Two more misses end the game.
    frames_to(60, 3'd2, 1'b0);
    miss_event(1'b0);
    frames_to(90, 3'd1, 1'b1);
    frames_to(60, 3'd2, 1'b0);
    miss_event(1'b0);
    tick();

    // Stray events in OVER have no effect.
    stray_pulses();

    // START held for 100 cycles restarts exactly once.
    start = 1'b1;
    m_st = 3'd1;
    m_score = 0;
    m_lives = 2'd3;
    m_dir = 1'b0;
    push(cyc + 1, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d outstanding, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
